uart_boot_loader: RTL
=====================

// Module: uart_boot_loader
// PURPOSE
//  Downstream consumer of the UART receiver's assembled 32-bit words. Parses a framed boot image
//  (magic, length, payload, checksum) and writes the payload into instruction memory. Holds the CPU
//  stalled while loading, then pulses a CPU reset on a good image. Replaces raw word-by-word imem
//  writes with a checked, bounded, timeout-protected load.
// PARAMETERS
//  MAGIC          32'h50524F47  first word of every frame ("PROG")
//  BASE_ADDR      32'h00000000  imem byte address of payload word 0
//  MAX_WORDS      1024          largest accepted payload length, in words
//  TIMEOUT_CYCLES 100000        max idle cycles between words once a frame has started
//  RST_CYCLES     16            width of the cpu_reset pulse after a good load
// PORTS
//  CLK        in   1   system clock
//  reset      in   1   asynchronous, active-high reset
//  prog_mode  in   1   loader enable, level; from the UART control register
//  word_valid in   1   1-cycle strobe: a new received word is on word_data
//  word_data  in   32  received word, little-endian assembled
//  imem_WE    out  1   instruction memory write strobe, 1 cycle
//  imem_A     out  32  imem byte address
//  imem_WD    out  32  imem write data
//  cpu_stall  out  1   hold the CPU pipeline
//  cpu_reset  out  1   CPU reset pulse after a successful load
//  done       out  1   sticky: last frame loaded and verified
//  error      out  1   sticky: bad magic/length/checksum or timeout
//  words_loaded out 16 payload words written in the current/last frame
// BEHAVIOUR
//  Reset values: all outputs 0. FSM = IDLE; counters and checksum accumulator = 0.
//  FSM states: IDLE, WAIT_MAGIC, WAIT_LEN, LOAD, WAIT_CSUM, RELEASE, FAIL.
//   IDLE: prog_mode rising -> WAIT_MAGIC. On entry to WAIT_MAGIC: clear done, error,
//    words_loaded, sum. cpu_stall=1 in every state except IDLE.
//   WAIT_MAGIC: word_valid & word_data==MAGIC -> WAIT_LEN; any other word is discarded
//    (resync, no error). The timeout counter does not run in this state.
//   WAIT_LEN: word N; N==0 or N>MAX_WORDS -> FAIL, else latch N -> LOAD.
//   LOAD: each word_valid -> next cycle imem_WE=1, imem_A=BASE_ADDR+4*words_loaded,
//    imem_WD=word, sum+=word (mod 2^32), words_loaded++. After the Nth word -> WAIT_CSUM.
//    Write latency is 1 cycle. Back-to-back word_valid on consecutive cycles is legal and must
//    produce consecutive imem_WE cycles.
//   WAIT_CSUM: word==sum -> RELEASE, else -> FAIL.
//   RELEASE: cpu_reset=1 for exactly RST_CYCLES cycles, cpu_stall stays 1 through them.
//    Then done=1 and the FSM waits in RELEASE with cpu_stall=0 until prog_mode falls -> IDLE.
//   FAIL: error=1, cpu_stall=1, no imem writes; prog_mode falls -> IDLE (error stays set).
//  Timeout: in WAIT_LEN, LOAD and WAIT_CSUM a counter counts cycles without word_valid and is
//   cleared by word_valid. At TIMEOUT_CYCLES -> FAIL.
//  prog_mode falling in any state other than RELEASE or FAIL -> IDLE immediately. An in-flight
//   imem write still completes that cycle. done=0; error is not set.
//  word_valid while in IDLE, RELEASE or FAIL: ignored.
//  Async reset mid-load: outputs drop to 0 within the cycle. Partially written imem is not rolled back.
//  words_loaded saturates at MAX_WORDS, 16-bit. Address arithmetic wraps mod 2^32.
// STRUCTURE
//  Shared package: FSM state encoding, default MAGIC value, frame word-type constants.
//  One sub-module, loader_timeout: counter with clear/enable/expire, reused by other bus timeouts.
//  Datapath (sum, address, length) stays in the top module.
// TESTING
//  Good frame: MAGIC, 3, 0x11,0x22,0x33, 0x66 -> imem writes @0x0/0x4/0x8, cpu_reset 16 cyc,
//   done=1, stall releases.
//  Checksum bad: MAGIC, 2, 0x1, 0x2, 0x4 -> two imem writes, then error=1, cpu_reset never asserted.
//  Resync: 0xDEADBEEF, MAGIC, 1, 0xA, 0xA -> first word ignored, load succeeds, error=0.
//  Length bounds: N=0 and N=MAX_WORDS+1 -> FAIL with zero imem writes; N=MAX_WORDS passes.
//  Timeout: MAGIC, 4, 1 word, then silence TIMEOUT_CYCLES -> error=1 at exactly that cycle.
//  Abort/reset: prog_mode drops after 2 of 4 words -> IDLE, stall=0. Reset pulse mid-LOAD
//   -> all outputs 0.

Source files
------------

// File: rtl/uart_boot_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM encoding, default frame
// magic and the word types that make up a boot frame.
package uart_boot_loader_pkg;

  localparam logic [31:0] DEFAULT_MAGIC = 32'h50524F47;  // "PROG"

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_MAGIC,
    ST_WAIT_LEN,
    ST_LOAD,
    ST_WAIT_CSUM,
    ST_RELEASE,
    ST_FAIL
  } state_t;

  typedef enum logic [1:0] {
    WT_MAGIC,
    WT_LEN,
    WT_PAYLOAD,
    WT_CSUM
  } word_type_t;

  // Which frame word the loader expects next while in a given state.
  function automatic word_type_t expected_word(input state_t s);
    unique case (s)
      ST_WAIT_LEN:  return WT_LEN;
      ST_LOAD:      return WT_PAYLOAD;
      ST_WAIT_CSUM: return WT_CSUM;
      default:      return WT_MAGIC;
    endcase
  endfunction

endpackage

// File: rtl/uart_boot_loader_if.sv
// Received-word stream plus instruction-memory write bus. The master side
// supplies words and observes writes; the loader is the slave.
interface uart_boot_loader_if;
  logic        word_valid;
  logic [31:0] word_data;
  logic        imem_WE;
  logic [31:0] imem_A;
  logic [31:0] imem_WD;

  modport master (
    output word_valid, word_data,
    input  imem_WE, imem_A, imem_WD
  );

  modport slave (
    input  word_valid, word_data,
    output imem_WE, imem_A, imem_WD
  );
endinterface

// File: rtl/uart_boot_loader_timeout.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags
// the LIMIT-th consecutive idle cycle.
module loader_timeout #(
  parameter int unsigned LIMIT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CW-1:0] cnt;

  assign expired = en & ~clr & (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != CW'(LIMIT - 1)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Boot image loader: parses MAGIC/length/payload/checksum frames from the UART
// word stream into instruction memory and sequences CPU stall and reset.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter logic [31:0] MAGIC          = DEFAULT_MAGIC,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned RST_CYCLES     = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              prog_mode,
  uart_boot_loader_if.slave bus,
  output logic              cpu_stall,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  localparam int unsigned RW = $clog2(RST_CYCLES + 1);

  state_t        state, state_nxt;
  logic          prog_mode_q;
  logic [31:0]   sum;
  logic [31:0]   addr;
  logic [15:0]   len;
  logic [RW-1:0] rel_cnt;
  logic          rel_done;
  logic          active;
  logic          tmo_expired;
  logic          accept_word;
  logic          last_word;
  logic          len_bad;
  logic          start;

  assign active      = (state == ST_WAIT_LEN) || (state == ST_LOAD) || (state == ST_WAIT_CSUM);
  assign accept_word = (state == ST_LOAD) && bus.word_valid && prog_mode;
  assign last_word   = (words_loaded + 16'd1) == len;
  assign len_bad     = (bus.word_data == '0) || (bus.word_data > 32'(MAX_WORDS));
  assign rel_done    = (rel_cnt == RW'(RST_CYCLES));
  assign start       = (state == ST_IDLE) && (state_nxt == ST_WAIT_MAGIC);

  loader_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (CLK),
    .rst     (reset),
    .clr     (bus.word_valid | ~active),
    .en      (active),
    .expired (tmo_expired)
  );

  always_comb begin
    state_nxt = state;
    cpu_stall = 1'b1;
    cpu_reset = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cpu_stall = 1'b0;
        if (prog_mode && !prog_mode_q) state_nxt = ST_WAIT_MAGIC;
      end
      ST_WAIT_MAGIC: begin
        if (!prog_mode) state_nxt = ST_IDLE;
        else if (bus.word_valid && bus.word_data == MAGIC) state_nxt = ST_WAIT_LEN;
      end
      ST_WAIT_LEN: begin
        if (!prog_mode) state_nxt = ST_IDLE;
        else if (bus.word_valid) state_nxt = len_bad ? ST_FAIL : ST_LOAD;
        else if (tmo_expired) state_nxt = ST_FAIL;
      end
      ST_LOAD: begin
        if (!prog_mode) state_nxt = ST_IDLE;
        else if (bus.word_valid) begin
          if (last_word) state_nxt = ST_WAIT_CSUM;
        end else if (tmo_expired) state_nxt = ST_FAIL;
      end
      ST_WAIT_CSUM: begin
        if (!prog_mode) state_nxt = ST_IDLE;
        else if (bus.word_valid) state_nxt = (bus.word_data == sum) ? ST_RELEASE : ST_FAIL;
        else if (tmo_expired) state_nxt = ST_FAIL;
      end
      // The full reset pulse is always delivered before prog_mode can end the session.
      ST_RELEASE: begin
        if (!rel_done) begin
          cpu_reset = 1'b1;
        end else begin
          cpu_stall = 1'b0;
          if (!prog_mode) state_nxt = ST_IDLE;
        end
      end
      ST_FAIL: begin
        if (!prog_mode) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      prog_mode_q  <= 1'b0;
      sum          <= '0;
      addr         <= '0;
      len          <= '0;
      rel_cnt      <= '0;
      words_loaded <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      bus.imem_WE  <= 1'b0;
      bus.imem_A   <= '0;
      bus.imem_WD  <= '0;
    end else begin
      state       <= state_nxt;
      prog_mode_q <= prog_mode;
      bus.imem_WE <= accept_word;

      if (accept_word) begin
        bus.imem_A  <= addr;
        bus.imem_WD <= bus.word_data;
        addr        <= addr + 32'd4;
        sum         <= sum + bus.word_data;
        if (words_loaded != 16'(MAX_WORDS)) words_loaded <= words_loaded + 16'd1;
      end

      if (state == ST_WAIT_LEN && bus.word_valid && prog_mode && !len_bad)
        len <= bus.word_data[15:0];

      if (state == ST_RELEASE) begin
        if (!rel_done) rel_cnt <= rel_cnt + RW'(1);
        if (rel_cnt == RW'(RST_CYCLES - 1)) done <= 1'b1;
      end else begin
        rel_cnt <= '0;
      end

      if (state_nxt == ST_FAIL && state != ST_FAIL) error <= 1'b1;

      if (start) begin
        done         <= 1'b0;
        error        <= 1'b0;
        words_loaded <= '0;
        sum          <= '0;
        addr         <= BASE_ADDR;
      end
    end
  end

endmodule
